// File: rtl/cp0_ctrl.sv
// MIPS coprocessor-0: SR/Cause/EPC/PRId, interrupt request and EPC for eret.
// Optional CP0_INT_SYNC_EN adds a 2-flop synchronizer on hwint ahead of IP.
module cp0_ctrl #(
    parameter logic [31:0] PRID_VALUE = 32'h4D49_5053,
    parameter logic [5:0]  IM_RESET   = 6'b000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] pc,
    input  logic [31:0] din,
    input  logic [4:0]  sel,
    input  logic        we,
    input  logic        exl_set,
    input  logic        exl_clr,
    input  logic [5:0]  hwint,
    output logic        intreq,
    output logic [29:0] epc,
    output logic [31:0] dout
);

    // The FSM state is SR.EXL itself.
    typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

    state_t      state, state_n;
    logic [5:0]  im, im_n;
    logic        ie, ie_n;
    logic [29:0] epc_n;
    logic [5:0]  ip;
    logic [5:0]  ip_src;

`ifdef CP0_INT_SYNC_EN
    logic [5:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= hwint;
            sync2 <= sync1;
        end
    end

    assign ip_src = sync2;
`else
    assign ip_src = hwint;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            im    <= IM_RESET;
            ie    <= 1'b0;
            ip    <= '0;
            epc   <= '0;
        end else begin
            state <= state_n;
            im    <= im_n;
            ie    <= ie_n;
            ip    <= ip_src;
            epc   <= epc_n;
        end
    end

    // exl_set beats exl_clr beats mtc0; a write alongside either is dropped.
    always_comb begin
        state_n = state;
        im_n    = im;
        ie_n    = ie;
        epc_n   = epc;
        if (exl_set) begin
            if (state == RUN) begin
                state_n = HANDLER;
                epc_n   = pc;
            end
        end else if (exl_clr) begin
            state_n = RUN;
        end else if (we) begin
            case (sel)
                5'd12: begin
                    im_n    = din[15:10];
                    ie_n    = din[0];
                    state_n = din[1] ? HANDLER : RUN;
                end
                5'd14:   epc_n = din[31:2];
                default: ;
            endcase
        end
    end

    always_comb begin
        intreq = (|(ip & im)) & ie & (state == RUN);
    end

    always_comb begin
        dout = '0;
        case (sel)
            5'd12:   dout = {16'b0, im, 8'b0, (state == HANDLER), ie};
            5'd13:   dout = {16'b0, ip, 10'b0};
            5'd14:   dout = {epc, 2'b00};
            5'd15:   dout = PRID_VALUE;
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios plus randomized traffic
// against a register-level reference model.
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] pc;
    logic [31:0] din;
    logic [4:0]  sel;
    logic        we;
    logic        exl_set;
    logic        exl_clr;
    logic [5:0]  hwint;
    logic        intreq;
    logic [29:0] epc;
    logic [31:0] dout;

`ifdef CP0_INT_SYNC_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 1;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    // reference model state
    logic [5:0]  m_im;
    logic        m_ie;
    logic        m_exl;
    logic [5:0]  m_ip;
    logic [29:0] m_epc;
    logic [5:0]  hq[$];

    cp0_ctrl #(.PRID_VALUE(32'h4D49_5053), .IM_RESET(6'b000000)) dut (
        .clk(clk), .rst(rst), .pc(pc), .din(din), .sel(sel), .we(we),
        .exl_set(exl_set), .exl_clr(exl_clr), .hwint(hwint),
        .intreq(intreq), .epc(epc), .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_im  = 6'b000000;
        m_ie  = 1'b0;
        m_exl = 1'b0;
        m_ip  = '0;
        m_epc = '0;
        hq.delete();
        for (int i = 0; i < int'(LAT); i++) hq.push_back(6'b0);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] s);
        case (s)
            5'd12:   return {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13:   return {16'b0, m_ip, 10'b0};
            5'd14:   return {m_epc, 2'b00};
            5'd15:   return 32'h4D49_5053;
            default: return 32'h0;
        endcase
    endfunction

    // IP is hwint as it stood LAT-1 edges before the current one.
    task automatic model_clock();
        hq.push_back(hwint);
        while (hq.size() > LAT) void'(hq.pop_front());
        m_ip = hq[0];
        if (exl_set) begin
            if (!m_exl) begin
                m_epc = pc;
                m_exl = 1'b1;
            end
        end else if (exl_clr) begin
            m_exl = 1'b0;
        end else if (we) begin
            if (sel == 5'd12) begin
                m_im  = din[15:10];
                m_exl = din[1];
                m_ie  = din[0];
            end else if (sel == 5'd14) begin
                m_epc = din[31:2];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_clock();
        #1;
    endtask

    task automatic drive(input logic es, input logic ec, input logic w, input logic [4:0] s,
                         input logic [31:0] d, input logic [29:0] p, input logic [5:0] hw);
        exl_set = es; exl_clr = ec; we = w; sel = s; din = d; pc = p; hwint = hw;
    endtask

    task automatic check_all(input string tag);
        logic model_int;
        #2;
        model_int = (|(m_ip & m_im)) & m_ie & ~m_exl;
        chk({tag, "_intreq"}, 32'(intreq), 32'(model_int));
        chk({tag, "_epc"}, 32'(epc), 32'(m_epc));
        chk({tag, "_dout"}, dout, model_read(sel));
    endtask

    task automatic mid_reset(input string tag);
        #1 rst = 1'b1;
        model_reset();
        sel = 5'd12; #1 chk({tag, "_sr"}, dout, 32'h0);
        chk({tag, "_intreq"}, 32'(intreq), 32'h0);
        chk({tag, "_epc"}, 32'(epc), 32'h0);
        sel = 5'd13; #1 chk({tag, "_cause"}, dout, 32'h0);
        sel = 5'd14; #1 chk({tag, "_epcreg"}, dout, 32'h0);
        drive(0, 0, 0, 5'd12, 32'h0, 30'h0, 6'b0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 5'd12, 32'h0, 30'h0, 6'b0);
        model_reset();
        #1 chk("por_sr", dout, 32'h0);
        chk("por_intreq", 32'(intreq), 32'h0);
        #6 rst = 1'b0;

        // mtc0 SR enabling IM0 and IE with hwint0 high
        drive(0, 0, 1, 5'd12, 32'h0000_0401, 30'h0, 6'b000001);
        check_all("t2w");
        tick();
        drive(0, 0, 0, 5'd12, 32'h0, 30'h0, 6'b000001);
        for (int i = 1; i < int'(LAT); i++) begin
            chk("t2_early", 32'(intreq), 32'h0);
            tick();
        end
        check_all("t2");
        chk("t2_intreq", 32'(intreq), 32'h1);

        // exception entry then eret
        drive(1, 0, 0, 5'd12, 32'h0, 30'h0000_0C05, 6'b000001);
        tick();
        check_all("t3s");
        chk("t3_epc", 32'(epc), 32'h0000_0C05);
        chk("t3_sr", dout, 32'h0000_0403);
        chk("t3_intreq", 32'(intreq), 32'h0);
        drive(0, 0, 0, 5'd14, 32'h0, 30'h0, 6'b000001);
        #1 chk("t3_epcreg", dout, 32'h0000_3014);
        drive(0, 1, 0, 5'd12, 32'h0, 30'h0, 6'b000001);
        tick();
        check_all("t3c");
        chk("t3_intreq2", 32'(intreq), 32'h1);

        // exl_set with a concurrent mtc0 EPC write
        drive(1, 0, 1, 5'd14, 32'hFFFF_FFFC, 30'h0000_1234, 6'b000001);
        tick();
        check_all("t4");
        chk("t4_epc", 32'(epc), 32'h0000_1234);
        drive(0, 1, 0, 5'd12, 32'h0, 30'h0, 6'b000001);
        tick();

        // PRId, unmapped select, read-only Cause
        drive(0, 0, 0, 5'd15, 32'h0, 30'h0, 6'b000001);
        #1 chk("t5_prid", dout, 32'h4D49_5053);
        sel = 5'd3;
        #1 chk("t5_sel3", dout, 32'h0);
        drive(0, 0, 1, 5'd13, 32'hFFFF_FFFF, 30'h0, 6'b000001);
        tick();
        drive(0, 0, 0, 5'd13, 32'h0, 30'h0, 6'b000001);
        check_all("t5");
        chk("t5_cause", dout, 32'h0000_0400);

        // mtc0 EPC: old value readable during the write cycle
        drive(0, 0, 1, 5'd14, 32'h0000_3007, 30'h0, 6'b000001);
        #1 chk("t6_old", dout, 32'h0000_48D0);
        tick();
        check_all("t6");
        chk("t6_epc", 32'(epc), 32'h0000_0C01);

        mid_reset("rst1");

        for (int n = 0; n < 600; n++) begin
            logic [4:0] s;
            case ($urandom_range(0, 6))
                0: s = 5'd12; 1: s = 5'd13; 2: s = 5'd14; 3: s = 5'd15;
                4: s = 5'd12; 5: s = 5'd14;
                default: s = 5'($urandom);
            endcase
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) == 0), s, $urandom, 30'($urandom),
                  ($urandom_range(0, 3) == 0) ? 6'($urandom) : hwint);
            check_all("rnd");
            tick();
            if (n == 300) begin
                check_all("rnd_pre");
                mid_reset("rst2");
            end
        end
        check_all("rnd_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
